gshare_branch_predictor: RTL and testbench
==========================================

# gshare_branch_predictor

Second-generation fetch-stage branch predictor for the RV32IM core. It adds three things over the current direct-mapped BTB/BHT unit:
- a parametrised set-associative BTB with per-entry branch type;
- a gshare PHT indexed by a speculative global history register, with checkpoint-based recovery on mispredict;
- a return address stack (RAS).

Prediction is combinational off `pc_i` in the fetch stage. Updates arrive from execute/commit.

## Interface
- `BTB_SETS`, 32, BTB sets, power of 2
- `BTB_WAYS`, 2, associativity, 1 or 2
- `BHT_ENTRIES`, 512, PHT 2-bit counters, power of 2
- `GHR_WIDTH`, 9, global history bits, ≤ log2(BHT_ENTRIES)
- `RAS_DEPTH`, 8, return stack entries, power of 2, ≥ 2

Ports:
- `clk_i`  in  1  single clock
- `rst_i`  in  1  asynchronous active-high reset
- `flush_i`  in  1  restart init sweep (invalidate all state)
- `ready_o`  out  1  low during init sweep
- `pred_valid_i`  in  1  fetch presents `pc_i` this cycle
- `pc_i`  in  `ADDR_WIDTH`  fetch PC
- `predict_taken_o`  out  1  predicted taken
- `predict_target_o`  out  `ADDR_WIDTH`  predicted next PC
- `btb_hit_o`  out  1  BTB tag hit
- `predict_ghr_o`  out  `GHR_WIDTH`  GHR snapshot, carried down the pipe with the instruction
- `update_valid_i`  in  1  resolved control-flow instruction
- `update_pc_i`  in  `ADDR_WIDTH`  its PC
- `update_type_i`  in  2  `btb_type_e`
- `update_taken_i`  in  1  actual outcome
- `update_target_i`  in  `ADDR_WIDTH`  actual target
- `update_ghr_i`  in  `GHR_WIDTH`  snapshot from `predict_ghr_o`
- `mispredict_i`  in  1  qualifies update as mispredicted (direction or target)

## Operation

**Indexing**
- Set = `pc[log2(BTB_SETS)+1:2]`.
- Tag = remaining upper bits.
- PHT index = `pc[log2(BHT_ENTRIES)+1:2]` XOR zero-extended GHR.
  - Predict side uses the live GHR.
  - Update side uses `update_ghr_i`.

**Init FSM (INIT → RUN)**
- Entered on reset or on `flush_i`.
- Sweeps a counter 0…max(`BTB_SETS`, `BHT_ENTRIES`)−1, one entry per cycle:
  - clears BTB valid bits and LRU bits;
  - sets PHT counters to 2'b01;
  - clears GHR and RAS.
- Goes to RUN after the last index. `ready_o` = 1 only in RUN.
- `flush_i` in RUN restarts the sweep at 0.
- Updates are ignored in INIT.

**Prediction (RUN)**
- On BTB hit:
  - BR: taken = PHT[idx][1], target = BTB target.
  - JAL and CALL: taken = 1.
  - RET: taken = 1; target = RAS top if the RAS is non-empty, else the BTB target.
- On miss: taken = 0, target = `pc_i`+4.
- In INIT: taken = 0, hit = 0, target = `pc_i`+4.

**Speculative state, at the clock edge when `pred_valid_i` and `ready_o`**
- Hit on BR: GHR <= {GHR[W−2:0], predicted taken}.
- Hit on CALL: push `pc_i`+4.
- Hit on RET: pop.

**Update, at the clock edge when `update_valid_i` and RUN**
- PHT: saturating increment/decrement at the update index for BR only.
- BTB, on tag hit in a way: rewrite target and type.
- BTB, on miss with `update_taken_i` = 1: allocate into the first invalid way (way 0 first), else the LRU way. Not-taken misses never allocate.
- LRU bit per set points away from the written way.

**Mispredict recovery**
- GHR <= {`update_ghr_i`[W−2:0], `update_taken_i`} for BR.
- GHR <= `update_ghr_i` for other types.
- RAS is not repaired.

**Simultaneous events**
- Mispredict wins over the same-cycle speculative GHR shift.
- A same-cycle RAS push/pop still applies.
- A same-cycle update to the set being predicted is not visible until the next cycle.
- Push and pop never coincide, because one PC is predicted per cycle.

**RAS behaviour**
- Overflow: circular; overwrites the oldest entry; count saturates at `RAS_DEPTH`.
- Underflow: pop on empty is a no-op.

## Timing
- Prediction outputs are combinational from `pc_i` and registered arrays; zero-cycle latency.
- All state updates take effect at the next rising edge.
- Init sweep lasts max(`BTB_SETS`, `BHT_ENTRIES`) cycles after `rst_i` deasserts.
- During reset: `ready_o`=0, `predict_taken_o`=0, `btb_hit_o`=0, `predict_ghr_o`=0, `predict_target_o`=`pc_i`+4.
- `rst_i` asserted mid-sweep or mid-run returns to INIT at index 0 immediately.

## Structure
- Add to `riscv_core_pkg`:
  - `btb_type_e` (`BTB_BR`=0, `BTB_JAL`=1, `BTB_CALL`=2, `BTB_RET`=3);
  - default parameter constants.
- `addr_t` and `ADDR_WIDTH` come from the package.
- One sub-module, `return_address_stack`:
  - ports: push, pop, push data, top, empty, clear;
  - behaviour: circular pointer plus saturating count.

## Test plan
- Reset, then idle: `ready_o` rises exactly 512 cycles after `rst_i` falls (defaults); lookup of 0x100 gives hit=0, target 0x104.
- Train BR at 0x200 → 0x180 taken three times: first update allocates, PHT moves 01→10→11; predict 0x200 gives hit=1, taken=1, target 0x180.
- Not-taken update for unseen PC 0x300: no allocation, hit=0; PHT entry 01→00.
- Three tags into set 0, all taken (0x000, 0x080, 0x100): third allocation evicts the LRU way (0x000); 0x080 and 0x100 hit.
- CALL at 0x400 (trained), then RET at 0x500 (trained): RET predicts target 0x404. Nine CALLs then nine RETs with depth 8: the ninth RET falls back to the BTB target.
- Predict BR with GHR=0x0AA while a concurrent mispredict arrives with `update_ghr_i`=0x055, taken=1: next GHR = 0x0AB; `flush_i` in RUN drops `ready_o` for the full sweep.

Source files
------------

// File: rtl/gshare_branch_predictor_pkg.sv
// gshare_branch_predictor_pkg: shared types and default sizing for the fetch-stage predictor
package gshare_branch_predictor_pkg;
    localparam int ADDR_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {
        BTB_BR   = 2'd0,
        BTB_JAL  = 2'd1,
        BTB_CALL = 2'd2,
        BTB_RET  = 2'd3
    } btb_type_e;
    localparam int DEF_BTB_SETS    = 32;
    localparam int DEF_BTB_WAYS    = 2;
    localparam int DEF_BHT_ENTRIES = 512;
    localparam int DEF_GHR_WIDTH   = 9;
    localparam int DEF_RAS_DEPTH   = 8;
endpackage

// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if: fetch-side prediction and execute-side update bundle
// master = pipeline driving lookups/updates, slave = predictor
interface gshare_branch_predictor_if
    import gshare_branch_predictor_pkg::*;
#(
    parameter int GHR_WIDTH = DEF_GHR_WIDTH
);
    logic                 flush_i;
    logic                 ready_o;
    logic                 pred_valid_i;
    addr_t                pc_i;
    logic                 predict_taken_o;
    addr_t                predict_target_o;
    logic                 btb_hit_o;
    logic [GHR_WIDTH-1:0] predict_ghr_o;
    logic                 update_valid_i;
    addr_t                update_pc_i;
    btb_type_e            update_type_i;
    logic                 update_taken_i;
    addr_t                update_target_i;
    logic [GHR_WIDTH-1:0] update_ghr_i;
    logic                 mispredict_i;

    modport master (
        output flush_i, pred_valid_i, pc_i, update_valid_i, update_pc_i, update_type_i,
               update_taken_i, update_target_i, update_ghr_i, mispredict_i,
        input  ready_o, predict_taken_o, predict_target_o, btb_hit_o, predict_ghr_o
    );
    modport slave (
        input  flush_i, pred_valid_i, pc_i, update_valid_i, update_pc_i, update_type_i,
               update_taken_i, update_target_i, update_ghr_i, mispredict_i,
        output ready_o, predict_taken_o, predict_target_o, btb_hit_o, predict_ghr_o
    );
endinterface

// File: rtl/gshare_branch_predictor_ras.sv
// return_address_stack: circular return stack with saturating occupancy count
// push_i/push_data_i write a return address, pop_i discards the top (no-op when empty),
// clear_i empties the stack, top_o/empty_o expose the current top entry
module return_address_stack
    import gshare_branch_predictor_pkg::*;
#(
    parameter int DEPTH = DEF_RAS_DEPTH
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clear_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  addr_t push_data_i,
    output addr_t top_o,
    output logic  empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    addr_t         mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    assign empty_o = cnt_q == '0;
    assign top_o   = mem_q[ptr_q - PW'(1)];

    // Overflow wraps the pointer onto the oldest entry while the count saturates
    always_comb begin
        ptr_d = clear_i ? '0 : push_i ? ptr_q + PW'(1) : (pop_i && !empty_o) ? ptr_q - PW'(1) : ptr_q;
        cnt_d = clear_i ? '0 : push_i ? (cnt_q == FULL ? cnt_q : cnt_q + (PW+1)'(1))
              : (pop_i && !empty_o) ? cnt_q - (PW+1)'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: set-associative BTB + gshare PHT + RAS fetch-stage predictor
// clk_i/rst_i plain; bp carries flush/ready, combinational lookup off pc_i and
// resolved-branch updates with mispredict recovery of the speculative GHR
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int BTB_SETS    = DEF_BTB_SETS,
    parameter int BTB_WAYS    = DEF_BTB_WAYS,
    parameter int BHT_ENTRIES = DEF_BHT_ENTRIES,
    parameter int GHR_WIDTH   = DEF_GHR_WIDTH,
    parameter int RAS_DEPTH   = DEF_RAS_DEPTH
) (
    input logic clk_i,
    input logic rst_i,
    gshare_branch_predictor_if.slave bp
);
    localparam int SET_BITS = $clog2(BTB_SETS);
    localparam int BHT_BITS = $clog2(BHT_ENTRIES);
    localparam int TAG_W    = ADDR_WIDTH - SET_BITS - 2;
    localparam int INIT_N   = BTB_SETS > BHT_ENTRIES ? BTB_SETS : BHT_ENTRIES;
    localparam int CNT_BITS = $clog2(INIT_N);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(INIT_N - 1);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [BTB_WAYS-1:0] valid_q  [BTB_SETS];
    logic [TAG_W-1:0]    tag_q    [BTB_SETS][BTB_WAYS];
    addr_t               target_q [BTB_SETS][BTB_WAYS];
    btb_type_e           type_q   [BTB_SETS][BTB_WAYS];
    logic [BTB_SETS-1:0] lru_q;
    logic [1:0]          pht_q    [BHT_ENTRIES];

    logic [0:0]           state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

    logic [SET_BITS-1:0] p_set, u_set;
    logic [TAG_W-1:0]    p_tag, u_tag;
    logic [BHT_BITS-1:0] p_idx, u_idx;
    logic                p_hit, u_hit, p_way, u_way, u_wr, ready, hit, taken, fire, upd, ras_empty;
    btb_type_e           p_type;
    addr_t               pc_plus4, ras_top;
    logic [1:0]          u_ctr;

    assign p_set    = bp.pc_i[SET_BITS+1:2];
    assign p_tag    = bp.pc_i[ADDR_WIDTH-1:SET_BITS+2];
    assign p_idx    = bp.pc_i[BHT_BITS+1:2] ^ BHT_BITS'(ghr_q);
    assign u_set    = bp.update_pc_i[SET_BITS+1:2];
    assign u_tag    = bp.update_pc_i[ADDR_WIDTH-1:SET_BITS+2];
    assign u_idx    = bp.update_pc_i[BHT_BITS+1:2] ^ BHT_BITS'(bp.update_ghr_i);
    assign pc_plus4 = bp.pc_i + ADDR_WIDTH'(4);

    // Descending scan so the lowest matching way wins
    always_comb begin
        p_hit = 1'b0;
        p_way = 1'b0;
        u_hit = 1'b0;
        u_way = 1'b0;
        for (int w = BTB_WAYS - 1; w >= 0; w--) begin
            if (valid_q[p_set][w] && tag_q[p_set][w] == p_tag) begin
                p_hit = 1'b1;
                p_way = 1'(w);
            end
            if (valid_q[u_set][w] && tag_q[u_set][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = 1'(w);
            end
        end
    end

    assign ready  = state_q == S_RUN;
    assign hit    = ready && p_hit;
    assign p_type = type_q[p_set][p_way];
    assign taken  = hit && (p_type != BTB_BR || pht_q[p_idx][1]);
    assign fire   = bp.pred_valid_i && hit;
    assign upd    = ready && bp.update_valid_i;

    assign bp.ready_o          = ready;
    assign bp.btb_hit_o        = hit;
    assign bp.predict_taken_o  = taken;
    assign bp.predict_ghr_o    = ghr_q;
    assign bp.predict_target_o = !hit ? pc_plus4
                               : (p_type == BTB_RET && !ras_empty) ? ras_top : target_q[p_set][p_way];

    // Allocation: existing way, else first invalid way, else LRU way
    assign u_wr  = u_hit ? u_way : !valid_q[u_set][0] ? 1'b0
                 : !valid_q[u_set][BTB_WAYS-1] ? 1'b1 : lru_q[u_set];
    assign u_ctr = bp.update_taken_i ? (pht_q[u_idx] == 2'b11 ? 2'b11 : pht_q[u_idx] + 2'd1)
                                     : (pht_q[u_idx] == 2'b00 ? 2'b00 : pht_q[u_idx] - 2'd1);

    assign state_d = bp.flush_i ? S_INIT : (state_q == S_INIT && cnt_q == LAST) ? S_RUN : state_q;
    assign cnt_d   = (bp.flush_i || ready) ? '0 : cnt_q + CNT_BITS'(1);
    // Mispredict recovery overrides the same-cycle speculative shift
    assign ghr_d   = (!ready || bp.flush_i) ? '0
                   : (upd && bp.mispredict_i) ? (bp.update_type_i == BTB_BR
                       ? {bp.update_ghr_i[GHR_WIDTH-2:0], bp.update_taken_i} : bp.update_ghr_i)
                   : (fire && p_type == BTB_BR) ? {ghr_q[GHR_WIDTH-2:0], taken} : ghr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ghr_q   <= ghr_d;
        end
    end

    // Arrays are cleared by the init sweep rather than by reset
    always_ff @(posedge clk_i) begin
        if (!ready) begin
            if (int'(cnt_q) < BTB_SETS) begin
                valid_q[SET_BITS'(cnt_q)] <= '0;
                lru_q[SET_BITS'(cnt_q)]   <= 1'b0;
            end
            if (int'(cnt_q) < BHT_ENTRIES) pht_q[BHT_BITS'(cnt_q)] <= 2'b01;
        end else if (upd) begin
            if (bp.update_type_i == BTB_BR) pht_q[u_idx] <= u_ctr;
            if (u_hit || bp.update_taken_i) begin
                valid_q[u_set][u_wr]  <= 1'b1;
                tag_q[u_set][u_wr]    <= u_tag;
                target_q[u_set][u_wr] <= bp.update_target_i;
                type_q[u_set][u_wr]   <= bp.update_type_i;
                lru_q[u_set]          <= BTB_WAYS == 2 && !u_wr;
            end
        end
    end

    return_address_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (!ready || bp.flush_i),
        .push_i      (fire && p_type == BTB_CALL),
        .pop_i       (fire && p_type == BTB_RET),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed + randomized check against a behavioural predictor model
module tb_gshare_branch_predictor;
    import gshare_branch_predictor_pkg::*;
    localparam int SETS = 32, WAYS = 2, BHT = 512, GW = 9, RD = 8, INIT_N = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_branch_predictor_if #(.GHR_WIDTH(GW)) bp ();
    gshare_branch_predictor #(
        .BTB_SETS(SETS), .BTB_WAYS(WAYS), .BHT_ENTRIES(BHT), .GHR_WIDTH(GW), .RAS_DEPTH(RD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bp    (bp)
    );

    int vectors = 0, miscompares = 0;

    bit          m_v   [SETS][WAYS];
    int unsigned m_tag [SETS][WAYS];
    int unsigned m_tgt [SETS][WAYS];
    int          m_ty  [SETS][WAYS];
    int          m_lru [SETS];
    int          m_pht [BHT];
    int          m_ghr;
    int unsigned m_ras [$];
    int          m_left;
    logic [31:0] pool [8] = '{32'h200, 32'h204, 32'h400, 32'h500, 32'h1000, 32'h1080, 32'h2004, 32'h3ff8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        m_left = INIT_N;
        m_ghr = 0;
        m_ras.delete();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
        end
        for (int i = 0; i < BHT; i++) m_pht[i] = 1;
    endfunction

    function automatic void mpred(input int unsigned pc, output bit hit, output bit tk,
                                  output int unsigned tgt, output int ty);
        int s;
        int unsigned tg;
        s = int'((pc >> 2) % SETS);
        tg = pc >> 7;
        hit = 1'b0;
        tk = 1'b0;
        tgt = pc + 4;
        ty = 0;
        if (m_left != 0) return;
        for (int w = 0; w < WAYS; w++)
            if (!hit && m_v[s][w] && m_tag[s][w] == tg) begin
                hit = 1'b1;
                ty = m_ty[s][w];
                tgt = m_tgt[s][w];
            end
        if (!hit) return;
        tk = (ty != 0) || (m_pht[int'((pc >> 2) % BHT) ^ m_ghr] >= 2);
        if (ty == 3 && m_ras.size() > 0) tgt = m_ras[$];
    endfunction

    task automatic check_outputs();
        bit h, t;
        int unsigned g;
        int ty;
        mpred(bp.pc_i, h, t, g, ty);
        chk("ready", 32'(bp.ready_o), 32'(m_left == 0));
        chk("hit", 32'(bp.btb_hit_o), 32'(h));
        chk("taken", 32'(bp.predict_taken_o), 32'(t));
        chk("target", bp.predict_target_o, g);
        chk("ghr", 32'(bp.predict_ghr_o), 32'(m_ghr));
    endtask

    task automatic model_edge();
        bit h, t, utk;
        int unsigned g, upc, tg;
        int ty, ng, uty, ughr, s, w, i;
        if (rst || bp.flush_i) begin
            m_clear();
            return;
        end
        if (m_left != 0) begin
            m_left--;
            return;
        end
        mpred(bp.pc_i, h, t, g, ty);
        ng = m_ghr;
        if (bp.pred_valid_i && h) begin
            if (ty == 0) ng = ((m_ghr << 1) | int'(t)) % 512;
            if (ty == 2) begin
                m_ras.push_back(bp.pc_i + 4);
                if (m_ras.size() > RD) void'(m_ras.pop_front());
            end
            if (ty == 3 && m_ras.size() > 0) void'(m_ras.pop_back());
        end
        if (bp.update_valid_i) begin
            upc = bp.update_pc_i;
            uty = int'(bp.update_type_i);
            utk = bp.update_taken_i;
            ughr = int'(bp.update_ghr_i);
            if (uty == 0) begin
                i = int'((upc >> 2) % BHT) ^ ughr;
                m_pht[i] = utk ? (m_pht[i] == 3 ? 3 : m_pht[i] + 1) : (m_pht[i] == 0 ? 0 : m_pht[i] - 1);
            end
            s = int'((upc >> 2) % SETS);
            tg = upc >> 7;
            w = -1;
            for (int k = 0; k < WAYS; k++) if (w < 0 && m_v[s][k] && m_tag[s][k] == tg) w = k;
            if (w < 0 && utk) w = !m_v[s][0] ? 0 : !m_v[s][1] ? 1 : m_lru[s];
            if (w >= 0) begin
                m_v[s][w] = 1'b1;
                m_tag[s][w] = tg;
                m_tgt[s][w] = bp.update_target_i;
                m_ty[s][w] = uty;
                m_lru[s] = 1 - w;
            end
            if (bp.mispredict_i) ng = (uty == 0) ? ((ughr << 1) | int'(utk)) % 512 : ughr;
        end
        m_ghr = ng;
    endtask

    task automatic idle();
        bp.flush_i = 1'b0;
        bp.pred_valid_i = 1'b0;
        bp.pc_i = '0;
        bp.update_valid_i = 1'b0;
        bp.update_pc_i = '0;
        bp.update_type_i = BTB_BR;
        bp.update_taken_i = 1'b0;
        bp.update_target_i = '0;
        bp.update_ghr_i = '0;
        bp.mispredict_i = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic upd(input logic [31:0] pc, input btb_type_e ty, input bit tk,
                       input logic [31:0] tgt, input bit mis, input logic [GW-1:0] g);
        idle();
        bp.update_valid_i = 1'b1;
        bp.update_pc_i = pc;
        bp.update_type_i = ty;
        bp.update_taken_i = tk;
        bp.update_target_i = tgt;
        bp.mispredict_i = mis;
        bp.update_ghr_i = g;
        cyc();
    endtask

    task automatic look(input logic [31:0] pc);
        idle();
        bp.pred_valid_i = 1'b1;
        bp.pc_i = pc;
        settle();
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bp.ready_o && n < 600) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n), 32'(INIT_N));
    endtask

    initial begin
        idle();
        m_clear();
        bp.pc_i = 32'h100;
        #2;
        check_outputs();
        chk("rst_ready", 32'(bp.ready_o), 32'd0);
        chk("rst_target", bp.predict_target_o, 32'h104);
        tick();
        rst = 1'b0;
        wait_ready("init_cycles");

        look(32'h100);
        chk("miss_hit", 32'(bp.btb_hit_o), 32'd0);
        chk("miss_target", bp.predict_target_o, 32'h104);
        tick();

        repeat (3) upd(32'h200, BTB_BR, 1'b1, 32'h180, 1'b0, 9'h000);
        look(32'h200);
        chk("br_hit", 32'(bp.btb_hit_o), 32'd1);
        chk("br_taken", 32'(bp.predict_taken_o), 32'd1);
        chk("br_target", bp.predict_target_o, 32'h180);
        tick();

        upd(32'h300, BTB_BR, 1'b0, 32'h380, 1'b0, 9'h000);
        look(32'h300);
        chk("nt_noalloc", 32'(bp.btb_hit_o), 32'd0);
        tick();

        upd(32'h000, BTB_JAL, 1'b1, 32'h040, 1'b0, 9'h000);
        upd(32'h080, BTB_JAL, 1'b1, 32'h0c0, 1'b0, 9'h000);
        upd(32'h100, BTB_JAL, 1'b1, 32'h140, 1'b0, 9'h000);
        look(32'h000);
        chk("evicted", 32'(bp.btb_hit_o), 32'd0);
        tick();
        look(32'h080);
        chk("kept_080", bp.predict_target_o, 32'h0c0);
        tick();
        look(32'h100);
        chk("kept_100", bp.predict_target_o, 32'h140);
        tick();

        upd(32'h400, BTB_CALL, 1'b1, 32'h1000, 1'b0, 9'h000);
        upd(32'h500, BTB_RET, 1'b1, 32'h900, 1'b0, 9'h000);
        look(32'h400);
        tick();
        look(32'h500);
        chk("ret_taken", 32'(bp.predict_taken_o), 32'd1);
        chk("ret_target", bp.predict_target_o, 32'h404);
        tick();
        repeat (9) begin
            look(32'h400);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            look(32'h500);
            chk(i == 8 ? "ret_underflow" : "ret_deep", bp.predict_target_o, i == 8 ? 32'h900 : 32'h404);
            tick();
        end

        upd(32'h200, BTB_BR, 1'b1, 32'h180, 1'b0, 9'h0AA);
        upd(32'h7000, BTB_JAL, 1'b0, 32'h0, 1'b1, 9'h0AA);
        look(32'h200);
        bp.update_valid_i = 1'b1;
        bp.update_pc_i = 32'h600;
        bp.update_type_i = BTB_BR;
        bp.update_taken_i = 1'b1;
        bp.update_target_i = 32'h640;
        bp.update_ghr_i = 9'h055;
        bp.mispredict_i = 1'b1;
        #1;
        check_outputs();
        chk("ghr_before", 32'(bp.predict_ghr_o), 32'h0AA);
        chk("conc_taken", 32'(bp.predict_taken_o), 32'd1);
        tick();
        chk("ghr_recover", 32'(bp.predict_ghr_o), 32'h0AB);

        for (int i = 0; i < 400; i++) begin
            idle();
            bp.pred_valid_i = 1'($urandom_range(0, 1));
            bp.pc_i = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hfffc) : pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 2) == 0) begin
                bp.update_valid_i = 1'b1;
                bp.update_pc_i = pool[$urandom_range(0, 7)];
                bp.update_type_i = btb_type_e'($urandom_range(0, 3));
                bp.update_taken_i = 1'($urandom_range(0, 1));
                bp.update_target_i = $urandom & 32'hfffffffc;
                bp.update_ghr_i = GW'($urandom_range(0, 511));
                bp.mispredict_i = ($urandom_range(0, 3) == 0);
            end
            cyc();
        end

        idle();
        bp.flush_i = 1'b1;
        cyc();
        idle();
        chk("flush_drop", 32'(bp.ready_o), 32'd0);
        wait_ready("flush_cycles");

        upd(32'h200, BTB_BR, 1'b1, 32'h180, 1'b0, 9'h000);
        look(32'h200);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bp.ready_o), 32'd0);
        chk("arst_hit", 32'(bp.btb_hit_o), 32'd0);
        chk("arst_target", bp.predict_target_o, 32'h204);
        tick();
        rst = 1'b0;
        wait_ready("arst_cycles");
        look(32'h200);
        chk("arst_cleared", 32'(bp.btb_hit_o), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
